// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the load/store unit and its RAM port
package riscv_pkg;

  localparam int RAM_PERIOD = 6;

  typedef enum logic [1:0] {
    MASK_B = 2'd0,
    MASK_H = 2'd1,
    MASK_W = 2'd2
  } mask_sel_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_BUSY = 2'd2,
    LSU_CAPT = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/riscv_load_ext.sv
// rtl/riscv_load_ext.sv - sign/zero extension of RAM read data by access size
module riscv_load_ext
  import riscv_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  mask_sel_t              mask,
  input  logic                   is_unsigned,
  input  logic [WORD_LENGTH-1:0] dout,
  output logic [WORD_LENGTH-1:0] rdata
);

  always_comb begin
    rdata = dout;
    case (mask)
      MASK_B:  rdata = {{(WORD_LENGTH-8){dout[7] & ~is_unsigned}}, dout[7:0]};
      MASK_H:  rdata = {{(WORD_LENGTH-16){dout[15] & ~is_unsigned}}, dout[15:0]};
      default: rdata = dout;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store initiator aligned to the byte-serial RAM's fixed window
// Optional: RISCV_LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses with resp_err.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int RAM_PERIOD  = riscv_pkg::RAM_PERIOD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  input  mask_sel_t              req_mask,
  input  logic                   req_unsigned,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   resp_err,
  output logic                   busy,
  output logic [ADDR_LENGTH-1:0] ram_addr,
  output logic                   ram_write_en,
  output logic [WORD_LENGTH-1:0] ram_wdata,
  output mask_sel_t              ram_mask_sel,
  input  logic [WORD_LENGTH-1:0] ram_dout
);

  localparam int PH_W = $clog2(RAM_PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RAM_PERIOD - 1);

  lsu_state_t             state_q, state_d;
  logic [PH_W-1:0]        ph;
  logic                   hold_we, hold_unsigned;
  logic [ADDR_LENGTH-1:0] hold_addr;
  logic [WORD_LENGTH-1:0] hold_wdata;
  mask_sel_t              hold_mask;
  logic [WORD_LENGTH-1:0] ext_rdata;
  logic                   accept, misalign, ph_last;

  assign req_ready    = (state_q == LSU_IDLE);
  assign busy         = ~req_ready;
  assign accept       = req_valid & req_ready;
  assign ph_last      = (ph == PH_LAST);
  assign ram_addr     = hold_addr;
  assign ram_wdata    = hold_wdata;
  assign ram_mask_sel = hold_mask;
  assign ram_write_en = (state_q == LSU_BUSY) & hold_we;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_mask == MASK_H) && req_addr[0]) ||
                    ((req_mask == MASK_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  riscv_load_ext #(.WORD_LENGTH(WORD_LENGTH)) u_load_ext (
    .mask        (hold_mask),
    .is_unsigned (hold_unsigned),
    .dout        (ram_dout),
    .rdata       (ext_rdata)
  );

  // WAIT parks until the RAM's LAST phase so BUSY always covers one full window
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept && !misalign) state_d = ph_last ? LSU_BUSY : LSU_WAIT;
      LSU_WAIT: if (ph_last) state_d = LSU_BUSY;
      LSU_BUSY: if (ph_last) state_d = LSU_CAPT;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LSU_IDLE;
      ph            <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      hold_we       <= 1'b0;
      hold_unsigned <= 1'b0;
      hold_addr     <= '0;
      hold_wdata    <= '0;
      hold_mask     <= MASK_B;
    end else begin
      state_q    <= state_d;
      ph         <= ph_last ? '0 : ph + PH_W'(1);
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      if (accept && !misalign) begin
        hold_we       <= req_we;
        hold_unsigned <= req_unsigned;
        hold_addr     <= req_addr;
        hold_wdata    <= req_wdata;
        hold_mask     <= req_mask;
      end
      if (accept && misalign) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end
      if (state_q == LSU_CAPT) begin
        resp_valid <= 1'b1;
        resp_rdata <= hold_we ? '0 : ext_rdata;
      end
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed self-checking bench for riscv_lsu with a behavioural byte-serial RAM
module tb_riscv_lsu;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  mask_sel_t   req_mask;
  logic        resp_valid, resp_err, busy, ram_write_en;
  logic [31:0] resp_rdata, ram_addr, ram_wdata, ram_dout;
  mask_sel_t   ram_mask_sel;

  logic [2:0]  tb_ph;
  logic [7:0]  mem [0:255];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_mask     (req_mask),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_write_en (ram_write_en),
    .ram_wdata    (ram_wdata),
    .ram_mask_sel (ram_mask_sel),
    .ram_dout     (ram_dout)
  );

  // RAM model: samples its inputs on the LAST phase, dout valid from the following INIT
  always @(posedge clk) begin
    if (reset) begin
      tb_ph <= 3'd0;
    end else begin
      tb_ph <= (tb_ph == 3'd5) ? 3'd0 : tb_ph + 3'd1;
      if (tb_ph == 3'd5) begin
        for (int i = 0; i < 4; i++)
          ram_dout[8*i +: 8] <= mem[(int'(ram_addr[7:0]) + i) % 256];
        if (ram_write_en) begin
          for (int i = 0; i < ((ram_mask_sel == MASK_B) ? 1 : (ram_mask_sel == MASK_H) ? 2 : 4); i++)
            mem[(int'(ram_addr[7:0]) + i) % 256] <= ram_wdata[8*i +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // phase > 5 means accept at whatever phase the unit is first ready
  task automatic do_op(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input mask_sel_t mask, input logic uns,
                       input int phase, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input logic [5:0] exp_wmask, input bit noise);
    int lat, ready_hits, busy_bad;
    logic [5:0] wmask;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready && (phase > 5 || int'(tb_ph) == phase)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      check({name, "_wait_ready"}, 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_mask = mask; req_unsigned = uns;
    lat = 0; wmask = '0; ready_hits = 0; busy_bad = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (noise) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
        req_wdata = 32'hFFFF_FFFF; req_mask = MASK_W;
      end else begin
        req_valid = 1'b0;
      end
      if (ram_write_en) wmask[tb_ph] = 1'b1;
      if (busy === req_ready) busy_bad++;
      if (resp_valid) begin
        lat = c;
        break;
      end
      if (req_ready) ready_hits++;
    end
    req_valid = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_rdata"}, resp_rdata, exp_rdata);
    check({name, "_err"}, 32'(resp_err), 32'(exp_err));
    check({name, "_wen_phases"}, 32'(wmask), 32'(exp_wmask));
    check({name, "_ready_while_busy"}, 32'(ready_hits), 32'd0);
    check({name, "_busy_vs_ready"}, 32'(busy_bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int resp_seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ram_dout = '0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_mask = MASK_B; req_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_write_en", 32'(ram_write_en), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_mask_sel", 32'(ram_mask_sel), 32'd0);

    do_op("sw_10",  1, 32'h10, 32'hDEADBEEF, MASK_W, 0, 5, 32'h0,        0, 8,  6'h3F, 0);
    do_op("lw_10",  0, 32'h10, 32'h0,        MASK_W, 0, 5, 32'hDEADBEEF, 0, 8,  6'h00, 0);
    do_op("lh_10",  0, 32'h10, 32'h0,        MASK_H, 0, 3, 32'hFFFFBEEF, 0, 10, 6'h00, 0);
    do_op("lhu_10", 0, 32'h10, 32'h0,        MASK_H, 1, 0, 32'h0000BEEF, 0, 13, 6'h00, 0);
    do_op("lb_13",  0, 32'h13, 32'h0,        MASK_B, 0, 1, 32'hFFFFFFDE, 0, 12, 6'h00, 0);
    do_op("lbu_13", 0, 32'h13, 32'h0,        MASK_B, 1, 4, 32'h000000DE, 0, 9,  6'h00, 0);

    do_op("sw_20",  1, 32'h20, 32'h0,        MASK_W, 0, 5, 32'h0,        0, 8,  6'h3F, 0);
    do_op("sb_20",  1, 32'h20, 32'h11223344, MASK_B, 0, 5, 32'h0,        0, 8,  6'h3F, 0);
    do_op("lw_20",  0, 32'h20, 32'h0,        MASK_W, 0, 5, 32'h00000044, 0, 8,  6'h00, 0);

    do_op("sw_24_ph2", 1, 32'h24, 32'h01020304, MASK_W, 0, 2, 32'h0,     0, 11, 6'h3F, 1);
    do_op("lw_24",  0, 32'h24, 32'h0,        MASK_W, 0, 5, 32'h01020304, 0, 8,  6'h00, 0);
    do_op("lw_10_after_noise", 0, 32'h10, 32'h0, MASK_W, 0, 5, 32'hDEADBEEF, 0, 8, 6'h00, 0);

    // reset during a store's BUSY window
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready && tb_ph == 3'd5) break;
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
    req_wdata = 32'h77777777; req_mask = MASK_W; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_pre_wen", 32'(ram_write_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_wen", 32'(ram_write_en), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_ph", 32'(tb_ph), 32'd0);
    resp_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) resp_seen++;
      @(negedge clk);
    end
    check("rstmid_no_resp", 32'(resp_seen), 32'd0);
    do_op("lw_10_after_rst", 0, 32'h10, 32'h0, MASK_W, 0, 5, 32'hDEADBEEF, 0, 8, 6'h00, 0);

    do_op("sb_14",  1, 32'h14, 32'h0000005A, MASK_B, 0, 5, 32'h0,        0, 8,  6'h3F, 0);
    do_op("lh_12",  0, 32'h12, 32'h0,        MASK_H, 0, 5, 32'hFFFFDEAD, 0, 8,  6'h00, 0);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    do_op("trap_lw_11", 0, 32'h11, 32'h0,    MASK_W, 0, 7, 32'h0,        1, 1,  6'h00, 0);
    do_op("trap_lh_13", 0, 32'h13, 32'h0,    MASK_H, 0, 7, 32'h0,        1, 1,  6'h00, 0);
    do_op("trap_sw_22", 1, 32'h22, 32'hFFFFFFFF, MASK_W, 0, 7, 32'h0,    1, 1,  6'h00, 0);
    do_op("lw_20_after_trap", 0, 32'h20, 32'h0, MASK_W, 0, 5, 32'h00000044, 0, 8, 6'h00, 0);
`else
    do_op("lw_11",  0, 32'h11, 32'h0,        MASK_W, 0, 5, 32'h5ADEADBE, 0, 8,  6'h00, 0);
    do_op("sw_wrap", 1, 32'hFFFFFFFE, 32'hCAFEF00D, MASK_W, 0, 5, 32'h0, 0, 8,  6'h3F, 0);
    do_op("lhu_0",  0, 32'h0,  32'h0,        MASK_H, 1, 5, 32'h0000CAFE, 0, 8,  6'h00, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
